// File: rtl/calc_entry_fsm.sv
// Calculator entry FSM: builds decimal operands from keypad strobes, evaluates +/- and drives a
// registered signed-magnitude display. Latency 1 cycle from strobe to outputs; no backpressure.
module calc_entry_fsm #(
  parameter int MAX_DIGITS = 4,
  parameter int MAG_W      = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic             is_num,
  input  logic             is_op,
  input  logic             is_eq,
  input  logic [3:0]       num_val,
  input  logic [1:0]       op_val,
  output logic [MAG_W-1:0] disp_mag,
  output logic             disp_neg,
  output logic             err,
  output logic [1:0]       op_pending,
  output logic             disp_upd
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic signed [MAG_W+1:0] MAXV = (MAG_W+2)'(10**MAX_DIGITS - 1);

  typedef enum logic [1:0] {S_A, S_B, S_RES, S_ERR} state_t;

  state_t                  state_q, state_d;
  logic signed [MAG_W:0]   a_q, a_d;
  logic [MAG_W-1:0]        b_q, b_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    b_seen_q, b_seen_d;
  logic signed [MAG_W:0]   r_q, r_d;
  logic [1:0]              op_q, op_d;
  logic [MAG_W-1:0]        mag_q, mag_d;
  logic                    neg_q, neg_d;
  logic                    err_q, err_d;
  logic                    upd_q, upd_d;

  logic                    k_num, k_op, k_eq, one_key, dig_ok, ovf;
  logic [MAG_W-1:0]        d_ext, cur, appended;
  logic [CW-1:0]           cnt_next, cnt_first;
  logic signed [MAG_W+1:0] a_w, b_w, sum;
  logic signed [MAG_W:0]   sum_n, shown, abs_v;

  always_comb begin
    one_key  = ({is_num, is_op, is_eq} == 3'b100) || ({is_num, is_op, is_eq} == 3'b010) ||
               ({is_num, is_op, is_eq} == 3'b001);
    k_num    = key_valid && one_key && is_num && (num_val <= 4'd9);
    k_op     = key_valid && one_key && is_op && ((op_val == 2'd1) || (op_val == 2'd2));
    k_eq     = key_valid && one_key && is_eq;
    d_ext    = MAG_W'(num_val);
    // In S_A the operand being typed is always non-negative, so its low bits are the magnitude
    cur      = (state_q == S_A) ? a_q[MAG_W-1:0] : b_q;
    dig_ok   = cnt_q < CW'(MAX_DIGITS);
    appended = cur * MAG_W'(10) + d_ext;
    cnt_next = ((num_val == 4'd0) && (cur == '0)) ? cnt_q : cnt_q + CW'(1);
    cnt_first = (num_val == 4'd0) ? CW'(0) : CW'(1);
    a_w      = {a_q[MAG_W], a_q};
    b_w      = {2'b00, b_q};
    sum      = (op_q == 2'd2) ? a_w - b_w : a_w + b_w;
    ovf      = (sum > MAXV) || (sum < -MAXV);
    sum_n    = sum[MAG_W:0];

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    b_seen_d = b_seen_q;
    r_d      = r_q;
    op_d     = op_q;

    case (state_q)
      S_A: begin
        if (k_num && dig_ok) begin
          a_d   = {1'b0, appended};
          cnt_d = cnt_next;
        end else if (k_op) begin
          op_d     = op_val;
          b_d      = '0;
          cnt_d    = '0;
          b_seen_d = 1'b0;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (k_num && dig_ok) begin
          b_d      = appended;
          cnt_d    = cnt_next;
          b_seen_d = 1'b1;
        end else if (k_op) begin
          if (!b_seen_q) begin
            op_d = op_val;
          end else if (ovf) begin
            op_d    = 2'd0;
            state_d = S_ERR;
          end else begin
            a_d      = sum_n;
            b_d      = '0;
            cnt_d    = '0;
            b_seen_d = 1'b0;
            op_d     = op_val;
          end
        end else if (k_eq) begin
          op_d = 2'd0;
          if (!b_seen_q) begin
            r_d     = a_q;
            state_d = S_RES;
          end else if (ovf) begin
            state_d = S_ERR;
          end else begin
            r_d     = sum_n;
            state_d = S_RES;
          end
        end
      end
      S_RES: begin
        if (k_num) begin
          a_d     = {1'b0, d_ext};
          cnt_d   = cnt_first;
          state_d = S_A;
        end else if (k_op) begin
          a_d      = r_q;
          op_d     = op_val;
          b_d      = '0;
          cnt_d    = '0;
          b_seen_d = 1'b0;
          state_d  = S_B;
        end
      end
      default: begin
        if (k_num) begin
          a_d     = {1'b0, d_ext};
          cnt_d   = cnt_first;
          state_d = S_A;
        end
      end
    endcase

    // Display is derived from the next state so it lands on the same edge as the key
    err_d = 1'b0;
    case (state_d)
      S_ERR: begin
        shown = '0;
        err_d = 1'b1;
      end
      S_RES:   shown = r_d;
      S_B:     shown = b_seen_d ? {1'b0, b_d} : a_d;
      default: shown = a_d;
    endcase
    abs_v = shown[MAG_W] ? -shown : shown;
    mag_d = abs_v[MAG_W-1:0];
    neg_d = shown[MAG_W];
    upd_d = (mag_d != mag_q) || (neg_d != neg_q) || (err_d != err_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      b_seen_q <= 1'b0;
      r_q      <= '0;
      op_q     <= 2'd0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      b_seen_q <= b_seen_d;
      r_q      <= r_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
    end
  end

  assign disp_mag   = mag_q;
  assign disp_neg   = neg_q;
  assign err        = err_q;
  assign op_pending = op_q;
  assign disp_upd   = upd_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed table-driven bench for calc_entry_fsm with hand-computed expected outputs.
module tb_calc_entry_fsm;

  logic        clk = 1'b0;
  logic        rst_n, key_valid, is_num, is_op, is_eq;
  logic [3:0]  num_val;
  logic [1:0]  op_val;
  logic [13:0] disp_mag;
  logic        disp_neg, err, disp_upd;
  logic [1:0]  op_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.MAX_DIGITS(4), .MAG_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .is_num(is_num), .is_op(is_op),
    .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .disp_mag(disp_mag),
    .disp_neg(disp_neg), .err(err), .op_pending(op_pending), .disp_upd(disp_upd)
  );

  typedef struct {
    logic        rst;
    logic        kv, n, o, e;
    logic [3:0]  nv;
    logic [1:0]  ov;
    logic [13:0] mag;
    logic        neg, er;
    logic [1:0]  op;
    logic        upd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit kv, bit n, bit o, bit e, int nv, int ov,
                              int mag, bit neg, bit er, int op, bit upd);
    vec_t v;
    v.rst = r;  v.kv = kv; v.n = n; v.o = o; v.e = e;
    v.nv = 4'(nv); v.ov = 2'(ov);
    v.mag = 14'(mag); v.neg = neg; v.er = er; v.op = 2'(op); v.upd = upd;
    return v;
  endfunction

  function automatic vec_t dg(int d, int mag, bit neg, bit er, int op, bit upd);
    return mk(0, 1, 1, 0, 0, d, 0, mag, neg, er, op, upd);
  endfunction

  function automatic vec_t opk(int o, int mag, bit neg, bit er, int op, bit upd);
    return mk(0, 1, 0, 1, 0, 0, o, mag, neg, er, op, upd);
  endfunction

  function automatic vec_t eqk(int mag, bit neg, bit er, int op, bit upd);
    return mk(0, 1, 0, 0, 1, 0, 0, mag, neg, er, op, upd);
  endfunction

  // Reset together with a live digit strobe: reset must win
  function automatic vec_t rs();
    return mk(1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string name, logic [13:0] mag, logic neg, logic er, logic [1:0] op,
                     logic upd);
    checks++;
    if ({disp_mag, disp_neg, err, op_pending, disp_upd} !== {mag, neg, er, op, upd}) begin
      errors++;
      $display("FAIL %s: got mag=%0d neg=%0b err=%0b op=%0d upd=%0b, want mag=%0d neg=%0b err=%0b op=%0d upd=%0b",
               name, disp_mag, disp_neg, err, op_pending, disp_upd, mag, neg, er, op, upd);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    num_val = '0; op_val = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    tbl.push_back(dg(1, 1, 0, 0, 0, 1));
    tbl.push_back(dg(2, 12, 0, 0, 0, 1));
    tbl.push_back(dg(3, 123, 0, 0, 0, 1));
    tbl.push_back(rs());
    tbl.push_back(dg(1, 1, 0, 0, 0, 1));
    tbl.push_back(dg(2, 12, 0, 0, 0, 1));
    tbl.push_back(opk(1, 12, 0, 0, 1, 0));
    tbl.push_back(dg(3, 3, 0, 0, 1, 1));
    tbl.push_back(dg(4, 34, 0, 0, 1, 1));
    tbl.push_back(eqk(46, 0, 0, 0, 1));
    tbl.push_back(dg(5, 5, 0, 0, 0, 1));
    tbl.push_back(opk(2, 5, 0, 0, 2, 0));
    tbl.push_back(dg(8, 8, 0, 0, 2, 1));
    tbl.push_back(eqk(3, 1, 0, 0, 1));
    tbl.push_back(opk(1, 3, 1, 0, 1, 0));
    tbl.push_back(dg(1, 1, 0, 0, 1, 1));
    tbl.push_back(dg(0, 10, 0, 0, 1, 1));
    tbl.push_back(eqk(7, 0, 0, 0, 1));
    tbl.push_back(dg(9, 9, 0, 0, 0, 1));
    tbl.push_back(dg(9, 99, 0, 0, 0, 1));
    tbl.push_back(dg(9, 999, 0, 0, 0, 1));
    tbl.push_back(dg(9, 9999, 0, 0, 0, 1));
    tbl.push_back(dg(9, 9999, 0, 0, 0, 0));
    tbl.push_back(opk(1, 9999, 0, 0, 1, 0));
    tbl.push_back(dg(1, 1, 0, 0, 1, 1));
    tbl.push_back(eqk(0, 0, 1, 0, 1));
    tbl.push_back(eqk(0, 0, 1, 0, 0));
    tbl.push_back(opk(1, 0, 0, 1, 0, 0));
    tbl.push_back(dg(4, 4, 0, 0, 0, 1));
    tbl.push_back(rs());
    tbl.push_back(dg(2, 2, 0, 0, 0, 1));
    tbl.push_back(opk(1, 2, 0, 0, 1, 0));
    tbl.push_back(dg(3, 3, 0, 0, 1, 1));
    tbl.push_back(opk(2, 5, 0, 0, 2, 1));
    tbl.push_back(dg(1, 1, 0, 0, 2, 1));
    tbl.push_back(eqk(4, 0, 0, 0, 1));
    tbl.push_back(opk(1, 4, 0, 0, 1, 0));
    tbl.push_back(opk(2, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 7, 1, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 3, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, 0, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 12, 0, 4, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 2, 0));
    tbl.push_back(rs());
    tbl.push_back(dg(1, 1, 0, 0, 0, 1));
    tbl.push_back(dg(2, 12, 0, 0, 0, 1));
    tbl.push_back(opk(1, 12, 0, 0, 1, 0));
    tbl.push_back(rs());
    tbl.push_back(dg(7, 7, 0, 0, 0, 1));
    tbl.push_back(rs());
    tbl.push_back(dg(0, 0, 0, 0, 0, 0));
    tbl.push_back(dg(0, 0, 0, 0, 0, 0));
    tbl.push_back(dg(1, 1, 0, 0, 0, 1));
    tbl.push_back(dg(2, 12, 0, 0, 0, 1));
    tbl.push_back(dg(3, 123, 0, 0, 0, 1));
    tbl.push_back(dg(4, 1234, 0, 0, 0, 1));
    tbl.push_back(dg(5, 1234, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = ~tbl[i].rst; key_valid = tbl[i].kv;
      is_num = tbl[i].n; is_op = tbl[i].o; is_eq = tbl[i].e;
      num_val = tbl[i].nv; op_val = tbl[i].ov;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), tbl[i].mag, tbl[i].neg, tbl[i].er, tbl[i].op, tbl[i].upd);
      @(negedge clk);
      rst_n = 1'b1; key_valid = 1'b0;
      @(posedge clk);
      #1 chk($sformatf("vec%0d_idle", i), tbl[i].mag, tbl[i].neg, tbl[i].er, tbl[i].op, 1'b0);
    end

    // Back-to-back strobes on consecutive cycles: each edge must update the display
    @(negedge clk);
    key_valid = 1'b1; is_num = 1'b1; is_op = 1'b0; is_eq = 1'b0; num_val = 4'd8;
    @(posedge clk);
    #1 chk("b2b_first", 1234, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin rst_n = 1'b1; num_val = 4'd6; end
    @(posedge clk);
    #1 chk("b2b_6", 6, 0, 0, 0, 1);
    @(negedge clk) num_val = 4'd1;
    @(posedge clk);
    #1 chk("b2b_61", 61, 0, 0, 0, 1);
    @(negedge clk) key_valid = 1'b0;
    @(posedge clk);
    #1 chk("b2b_idle", 61, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
